uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among `NREQ` byte requesters. It sits between client logic and the transmitter in the UART top level. The arbiter accepts one byte at a time and issues a one-cycle start to the transmitter. It holds the data stable until the transmitter's `done_t` pulse, then enforces an inter-frame gap. A watchdog flags a transmitter that never completes.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `DATA_W`, 8: byte width.
- `TIMEOUT`, 4095: maximum cycles in WAIT before the transaction is abandoned.
- `GAP_CYC`, 2: idle cycles after each frame before the next grant (0 allowed).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  bit i = requester i has a byte pending; held until its ack.
- `req_data`  in  NREQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W].
- `ack`  out  NREQ  one-cycle pulse; byte of requester i latched.
- `grant_id`  out  clog2(NREQ)  index of the current or last granted requester.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  DATA_W  byte to transmitter; stable from `tx_start` until the state leaves WAIT.
- `done_t`  in  1  transmitter frame-complete pulse.
- `busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  sticky; set on watchdog expiry.
- `err_clr`  in  1  clears `timeout_err`.

## Operation
- States: IDLE, START, WAIT, GAP.
- IDLE:
  - `req` is sampled only in IDLE.
  - If any bit is set, pick the winner by round-robin starting at (last_grant+1) mod NREQ.
  - Latch `req_data` slice into `tx_data`, set `grant_id`, pulse `ack[winner]`, go to START.
  - If no bit is set, stay in IDLE.
- START: `tx_start`=1 for exactly this cycle; go to WAIT; clear the watchdog counter.
- WAIT:
  - Counter increments each cycle.
  - `done_t`=1 → go to GAP (or to IDLE if GAP_CYC=0).
  - Counter reaches TIMEOUT-1 without `done_t` → set `timeout_err`, go to GAP/IDLE as above.
  - If `done_t` arrives in the same cycle as expiry, `done_t` wins: no error.
- GAP: stay GAP_CYC cycles, then go to IDLE.
- After reset last_grant = NREQ-1, so requester 0 has top priority first.
- last_grant updates to the winner at each grant.
- `done_t` outside WAIT is ignored, including a pulse during START.
- `timeout_err`:
  - Set has priority over `err_clr` in the same cycle.
  - Error does not block further arbitration.
- Requester protocol:
  - Requester sees `ack` during the START cycle.
  - It must drop `req` or present the next byte before the arbiter returns to IDLE.
  - A `req` dropped before being sampled is simply never served.
- Reset mid-operation: abort immediately. Transmitter-side completion of an aborted frame is ignored.

## Timing
- All outputs registered.
- Reset values:
  - `ack`=0, `tx_start`=0, `busy`=0, `timeout_err`=0.
  - `tx_data`=0, `grant_id`=NREQ-1.
  - State = IDLE.
- `req` high at edge k (in IDLE):
  - `ack` and new `grant_id`/`tx_data` valid in cycle k+1.
  - `tx_start` in cycle k+2.
  - `busy` high from k+1.
- `done_t` at edge m (in WAIT): GAP occupies cycles m+1 … m+GAP_CYC; IDLE in m+GAP_CYC+1; earliest next `ack` in m+GAP_CYC+2.
- With GAP_CYC=0: IDLE at m+1, next `ack` at m+2.
- Watchdog: WAIT lasts at most TIMEOUT cycles. `timeout_err` rises on the cycle after the last WAIT cycle.
- Minimum grant-to-grant spacing: 3+GAP_CYC cycles (done_t in first WAIT cycle).

## Test plan
- Reset values: assert `rst` 3 cycles → all outputs at reset values, `grant_id`=3, `busy`=0.
- Single request:
  - Stimulus: `req`=0001 with byte 0x95, `done_t` 40 cycles after `tx_start`.
  - Required: `ack`=0001 one cycle, `tx_start` next cycle, `tx_data`=0x95 held to `done_t`, `busy` low GAP_CYC+1 cycles after `done_t`.
- Simultaneous requests:
  - Stimulus: `req`=1111 with bytes 0xA0..0xA3, each requester dropping after its ack.
  - Required: grants 0,1,2,3 in order; `tx_data` sequence 0xA0,0xA1,0xA2,0xA3.
- Fairness: requesters 0 and 2 hold `req` continuously (re-presenting a byte after each ack) → grants alternate 0,2,0,2; never 0,0.
- Timeout:
  - Stimulus: TIMEOUT=16, no `done_t`.
  - Required: `timeout_err`=1 after 16 WAIT cycles; next grant proceeds; `err_clr` pulse → 0.
  - Coincident `done_t` and expiry → no error.
- Stray done and reset mid-WAIT:
  - `done_t` during START or IDLE → no state change.
  - `rst` mid-WAIT → IDLE and reset values the next cycle; a later `done_t` is ignored.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// Ports: clk/rst (sync, active-high); req/req_data in, ack/grant_id out;
//   tx_start/tx_data to transmitter, done_t from it; busy, timeout_err, err_clr.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4095,
    parameter int GAP_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DATA_W-1:0]  req_data,
    output logic [NREQ-1:0]         ack,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    done_t,
    output logic                    busy,
    output logic                    timeout_err,
    input  logic                    err_clr
);
    localparam int ID_W    = $clog2(NREQ);
    localparam int CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST =
        CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    // With no gap the frame end drops straight back to arbitration.
    localparam state_t POST_WAIT = (GAP_CYC > 0) ? GAP : IDLE;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [ID_W-1:0]     win;
    int                  win_i;
    logic                found;
    int                  idx;

    // Scan from the requester after the last grant; the first hit wins.
    always_comb begin
        win   = '0;
        win_i = 0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(grant_q) + off) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
                win_i = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        grant_d = grant_q;
        data_d  = data_q;
        err_d   = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = START;
                    ack_d[win] = 1'b1;
                    grant_d    = win;
                    data_d     = req_data[win_i*DATA_W +: DATA_W];
                end
            end
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A completion in the expiry cycle is a good frame.
                if (done_t) begin
                    state_d = POST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = POST_WAIT;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end
            end
            GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        start_d = (state_q == START);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= '0;
            grant_q <= ID_W'(NREQ - 1);
            data_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign ack         = ack_q;
    assign grant_id    = grant_q;
    assign tx_start    = start_q;
    assign tx_data     = data_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: main instance (defaults) plus a
// short-watchdog, zero-gap instance sharing the same inputs.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        done_t;
    logic        err_clr;

    logic [3:0]  ack, w_ack;
    logic [1:0]  grant_id, w_grant_id;
    logic        tx_start, w_tx_start;
    logic [7:0]  tx_data, w_tx_data;
    logic        busy, w_busy;
    logic        timeout_err, w_timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ(4), .DATA_W(8), .TIMEOUT(4095), .GAP_CYC(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .grant_id(grant_id), .tx_start(tx_start),
        .tx_data(tx_data), .done_t(done_t), .busy(busy),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    uart_tx_arbiter #(
        .NREQ(4), .DATA_W(8), .TIMEOUT(16), .GAP_CYC(0)
    ) wdut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(w_ack), .grant_id(w_grant_id), .tx_start(w_tx_start),
        .tx_data(w_tx_data), .done_t(done_t), .busy(w_busy),
        .timeout_err(w_timeout_err), .err_clr(err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_data = '0; done_t = 1'b0; err_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_data = '0; done_t = 1'b0; err_clr = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({ack, tx_start, busy, timeout_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl: ack=%b st=%b busy=%b err=%b want 0",
                     ack, tx_start, busy, timeout_err);
        end
        checks++;
        if (tx_data !== 8'h00 || grant_id !== 2'd3) begin
            errors++;
            $display("FAIL reset_data: data=%h gid=%0d want 00/3",
                     tx_data, grant_id);
        end
        checks++;
        if (w_grant_id !== 2'd3 || w_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_wd: gid=%0d busy=%b want 3/0",
                     w_grant_id, w_busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int bad;
        do_reset();
        req_data[7:0] = 8'h95;
        req = 4'b0001;
        tick();
        checks++;
        if (ack !== 4'b0001 || grant_id !== 2'd0 || tx_data !== 8'h95 ||
            busy !== 1'b1 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: ack=%b gid=%0d data=%h busy=%b st=%b",
                     ack, grant_id, tx_data, busy, tx_start);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (ack !== 4'b0000 || tx_start !== 1'b1) begin
            errors++;
            $display("FAIL single_start: ack=%b st=%b want 0000/1",
                     ack, tx_start);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tx_data !== 8'h95 || tx_start !== 1'b0 || busy !== 1'b1)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_hold: %0d bad cycles want 0", bad);
        end
        done_t = 1'b1;
        tick();
        done_t = 1'b0;
        checks++;
        if (busy !== 1'b1 || tx_data !== 8'h95) begin
            errors++;
            $display("FAIL single_gap1: busy=%b data=%h want 1/95",
                     busy, tx_data);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gap2: busy=%b want 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        do_reset();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (ack === 4'b0 && n < 20) begin
                tick();
                n++;
            end
            if (g > 0) begin
                checks++;
                if (n !== 3) begin
                    errors++;
                    $display("FAIL sim_spacing%0d: %0d want 3", g, n);
                end
            end
            checks++;
            if (ack !== 4'(1 << g) || grant_id !== 2'(g) ||
                tx_data !== 8'(8'hA0 + g)) begin
                errors++;
                $display("FAIL sim_grant%0d: ack=%b gid=%0d data=%h",
                         g, ack, grant_id, tx_data);
            end
            req = req & ~ack;
            tick();
            done_t = 1'b1;
            tick();
            done_t = 1'b0;
        end
    endtask

    task automatic test_fairness();
        int n;
        logic [1:0] exp_id[4] = '{2'd0, 2'd2, 2'd0, 2'd2};
        logic [7:0] exp_d[4]  = '{8'h10, 8'h20, 8'h11, 8'h21};
        do_reset();
        req_data[7:0]   = 8'h10;
        req_data[23:16] = 8'h20;
        req = 4'b0101;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (ack === 4'b0 && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (grant_id !== exp_id[g] || tx_data !== exp_d[g]) begin
                errors++;
                $display("FAIL fair%0d: gid=%0d data=%h want %0d/%h",
                         g, grant_id, tx_data, exp_id[g], exp_d[g]);
            end
            if (ack[0]) req_data[7:0] = req_data[7:0] + 8'd1;
            if (ack[2]) req_data[23:16] = req_data[23:16] + 8'd1;
            tick();
            done_t = 1'b1;
            tick();
            done_t = 1'b0;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req_data[15:8] = 8'h5A;
        req = 4'b0010;
        tick();
        checks++;
        if (w_ack !== 4'b0010 || w_grant_id !== 2'd1) begin
            errors++;
            $display("FAIL to_ack: ack=%b gid=%0d want 0010/1",
                     w_ack, w_grant_id);
        end
        req = 4'b0000;
        tick();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (w_timeout_err !== 1'b0 || w_busy !== 1'b1) begin
            errors++;
            $display("FAIL to_early: err=%b busy=%b want 0/1",
                     w_timeout_err, w_busy);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (w_timeout_err !== 1'b1 || w_busy !== 1'b0) begin
            errors++;
            $display("FAIL to_expire: err=%b busy=%b want 1/0",
                     w_timeout_err, w_busy);
        end
        req_data[23:16] = 8'h77;
        req = 4'b0100;
        tick();
        checks++;
        if (w_ack !== 4'b0100 || w_grant_id !== 2'd2 ||
            w_tx_data !== 8'h77 || w_timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_next: ack=%b gid=%0d data=%h err=%b",
                     w_ack, w_grant_id, w_tx_data, w_timeout_err);
        end
        req = 4'b0000;
        tick();
        done_t = 1'b1;
        tick();
        done_t = 1'b0;
        checks++;
        if (w_busy !== 1'b0 || w_timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_nogap: busy=%b err=%b want 0/1",
                     w_busy, w_timeout_err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (w_timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL to_clr: err=%b want 0", w_timeout_err);
        end
    endtask

    task automatic test_coincident();
        do_reset();
        req_data[15:8] = 8'h66;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        for (int i = 0; i < 15; i++) tick();
        done_t = 1'b1;
        tick();
        done_t = 1'b0;
        checks++;
        if (w_timeout_err !== 1'b0 || w_busy !== 1'b0) begin
            errors++;
            $display("FAIL coincide: err=%b busy=%b want 0/0",
                     w_timeout_err, w_busy);
        end
    endtask

    task automatic test_stray_reset();
        do_reset();
        done_t = 1'b1;
        tick();
        done_t = 1'b0;
        checks++;
        if (busy !== 1'b0 || ack !== 4'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: busy=%b ack=%b st=%b want 0",
                     busy, ack, tx_start);
        end
        req_data[7:0] = 8'h3C;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        done_t = 1'b1;
        tick();
        done_t = 1'b0;
        checks++;
        if (tx_start !== 1'b1) begin
            errors++;
            $display("FAIL stray_start: st=%b want 1", tx_start);
        end
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL stray_wait: busy=%b want 1", busy);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || ack !== 4'b0 || tx_start !== 1'b0 ||
            tx_data !== 8'h00 || grant_id !== 2'd3) begin
            errors++;
            $display("FAIL midrst: busy=%b ack=%b st=%b data=%h gid=%0d",
                     busy, ack, tx_start, tx_data, grant_id);
        end
        rst = 1'b0;
        done_t = 1'b1;
        tick();
        done_t = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL midrst_done: busy=%b st=%b want 0/0",
                     busy, tx_start);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_coincident();
        test_stray_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
